// File: rtl/rat_intr_pkg.sv
// Shared constants for the interrupt controller: default source count, I/O port map
// and the layout of the CAUSE register.
package rat_intr_pkg;

  localparam int NUM_SRC_DEF = 4;

  localparam logic [7:0] MASK_PORT_DEF  = 8'h20;
  localparam logic [7:0] PEND_PORT_DEF  = 8'h21;
  localparam logic [7:0] CAUSE_PORT_DEF = 8'h22;

  localparam int   CAUSE_VLD_POS = 7;
  localparam int   CAUSE_IDX_MSB = 2;
  localparam int   CAUSE_IDX_LSB = 0;
  localparam int   CAUSE_IDX_W   = CAUSE_IDX_MSB - CAUSE_IDX_LSB + 1;
  localparam logic CAUSE_VLD     = 1'b1;

  // CAUSE = {valid, 4'b0, index}
  function automatic logic [7:0] make_cause(input logic [CAUSE_IDX_W-1:0] idx);
    make_cause = '0;
    make_cause[CAUSE_VLD_POS] = CAUSE_VLD;
    make_cause[CAUSE_IDX_MSB:CAUSE_IDX_LSB] = idx;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Control-unit side bus of the interrupt controller: IRQ lines, flag control,
// acknowledge and the I/O port read/write path.
interface intr_ctrl_if
  import rat_intr_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
);
  logic [NUM_SRC-1:0] IRQ_IN;
  logic               I_SET;
  logic               I_CLR;
  logic               INTR_ACK;
  logic               IO_STRB;
  logic [7:0]         PORT_ID;
  logic [7:0]         OUT_PORT;
  logic               INTR;
  logic               I_FLAG;
  logic [7:0]         IN_DATA;
  logic               IN_HIT;

  modport master (
    output IRQ_IN, I_SET, I_CLR, INTR_ACK, IO_STRB, PORT_ID, OUT_PORT,
    input  INTR, I_FLAG, IN_DATA, IN_HIT
  );

  modport slave (
    input  IRQ_IN, I_SET, I_CLR, INTR_ACK, IO_STRB, PORT_ID, OUT_PORT,
    output INTR, I_FLAG, IN_DATA, IN_HIT
  );
endinterface

// File: rtl/intr_ctrl_irq_edge_sync.sv
// Two-flop synchronizer plus previous-value flop for one asynchronous IRQ line;
// flags a single-cycle rising edge on the synchronized value.
module irq_edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic irq_async,
  output logic irq_edge
);
  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= irq_async;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign irq_edge = sync_p1 & ~prev_p2;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-captured pending bits, mask, enable flag, lowest-index
// priority acknowledge with CAUSE capture, and an I/O-port register file.
module intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         NUM_SRC       = NUM_SRC_DEF,
  parameter logic [7:0] MASK_PORT_ID  = MASK_PORT_DEF,
  parameter logic [7:0] PEND_PORT_ID  = PEND_PORT_DEF,
  parameter logic [7:0] CAUSE_PORT_ID = CAUSE_PORT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  intr_ctrl_if.slave  bus
);
  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);

  logic [NUM_SRC-1:0]     mask;
  logic [NUM_SRC-1:0]     pend;
  logic [7:0]             cause;
  logic                   i_flag;

  logic [NUM_SRC-1:0]     edge_det;
  logic [NUM_SRC-1:0]     active;
  logic                   ack_vld;
  logic [CAUSE_IDX_W-1:0] ack_idx;
  logic [NUM_SRC-1:0]     ack_clr;
  logic                   wr_mask;
  logic                   wr_pend;
  logic [NUM_SRC-1:0]     w1c_clr;
  logic [NUM_SRC-1:0]     pend_nxt;
  logic [7:0]             in_data;
  logic                   unused_out;

  function automatic logic [CAUSE_IDX_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CAUSE_IDX_W'(i);
    end
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync u_sync (
      .CLK       (CLK),
      .RESET     (RESET),
      .irq_async (bus.IRQ_IN[g]),
      .irq_edge  (edge_det[g])
    );
  end

  assign active  = pend & mask;
  assign ack_vld = bus.INTR_ACK & (|active);
  assign ack_idx = lowest_idx(active);
  // Isolate the lowest set bit so the clear matches the encoded index.
  assign ack_clr = bus.INTR_ACK ? (active & (~active + SRC_ONE)) : '0;

  assign wr_mask = bus.IO_STRB && (bus.PORT_ID == MASK_PORT_ID);
  assign wr_pend = bus.IO_STRB && (bus.PORT_ID == PEND_PORT_ID);
  assign w1c_clr = wr_pend ? bus.OUT_PORT[NUM_SRC-1:0] : '0;

  // A fresh edge overrides any clear of the same bit so no event is lost.
  assign pend_nxt = (pend & ~(ack_clr | w1c_clr)) | edge_det;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask   <= '0;
      pend   <= '0;
      cause  <= '0;
      i_flag <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (wr_mask) mask <= bus.OUT_PORT[NUM_SRC-1:0];
      if (ack_vld) cause <= make_cause(ack_idx);
      if (bus.I_CLR)      i_flag <= 1'b0;
      else if (bus.I_SET) i_flag <= 1'b1;
    end
  end

  always_comb begin
    in_data = 8'h00;
    if (bus.PORT_ID == MASK_PORT_ID)       in_data[NUM_SRC-1:0] = mask;
    else if (bus.PORT_ID == PEND_PORT_ID)  in_data[NUM_SRC-1:0] = pend;
    else if (bus.PORT_ID == CAUSE_PORT_ID) in_data = cause;
  end

  assign bus.IN_DATA = in_data;
  assign bus.IN_HIT  = (bus.PORT_ID == MASK_PORT_ID) || (bus.PORT_ID == PEND_PORT_ID) ||
                       (bus.PORT_ID == CAUSE_PORT_ID);
  assign bus.INTR    = i_flag & (|active);
  assign bus.I_FLAG  = i_flag;

  assign unused_out = ^bus.OUT_PORT;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reset, flag control, capture/ack priority, masking,
// set-vs-clear collisions, port decode and mid-operation reset.
module tb_intr_ctrl;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] rd;

  intr_ctrl_if #(.NUM_SRC(4)) bus ();

  intr_ctrl #(.NUM_SRC(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_port(input logic [7:0] p, output logic [7:0] d);
    bus.PORT_ID = p;
    #1;
    d = bus.IN_DATA;
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    bus.PORT_ID  = p;
    bus.OUT_PORT = d;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic ack();
    bus.INTR_ACK = 1'b1;
    tick();
    bus.INTR_ACK = 1'b0;
  endtask

  task automatic test_reset();
    bus.PORT_ID = 8'h20;
    #1;
    checks++; if (bus.IN_DATA !== 8'h00) begin errors++; $display("FAIL rst_mask got %h want 00", bus.IN_DATA); end
    checks++; if (bus.IN_HIT !== 1'b1) begin errors++; $display("FAIL rst_hit got %b want 1", bus.IN_HIT); end
    checks++; if (bus.INTR !== 1'b0) begin errors++; $display("FAIL rst_intr got %b want 0", bus.INTR); end
    checks++; if (bus.I_FLAG !== 1'b0) begin errors++; $display("FAIL rst_iflag got %b want 0", bus.I_FLAG); end
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_iflag();
    bus.I_SET = 1'b1; bus.I_CLR = 1'b1;
    tick();
    checks++; if (bus.I_FLAG !== 1'b0) begin errors++; $display("FAIL iflag_both got %b want 0", bus.I_FLAG); end
    bus.I_CLR = 1'b0;
    tick();
    checks++; if (bus.I_FLAG !== 1'b1) begin errors++; $display("FAIL iflag_set got %b want 1", bus.I_FLAG); end
    bus.I_SET = 1'b0; bus.I_CLR = 1'b1;
    tick();
    bus.I_CLR = 1'b0;
    checks++; if (bus.I_FLAG !== 1'b0) begin errors++; $display("FAIL iflag_clr got %b want 0", bus.I_FLAG); end
    ack();
    read_port(8'h22, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL empty_ack_cause got %h want 00", rd); end
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL empty_ack_pend got %h want 00", rd); end
  endtask

  task automatic test_single_irq();
    bus.I_SET = 1'b1; tick(); bus.I_SET = 1'b0;
    io_write(8'h20, 8'h0F);
    bus.IRQ_IN = 4'b0100;
    ticks(2);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL pend_early got %h want 00", rd); end
    tick();
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h04) begin errors++; $display("FAIL pend_k2 got %h want 04", rd); end
    checks++; if (bus.INTR !== 1'b1) begin errors++; $display("FAIL intr_single got %b want 1", bus.INTR); end
    bus.IRQ_IN = 4'b0000;
    ack();
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL pend_after_ack got %h want 00", rd); end
    read_port(8'h22, rd);
    checks++; if (rd !== 8'h82) begin errors++; $display("FAIL cause_single got %h want 82", rd); end
    checks++; if (bus.INTR !== 1'b0) begin errors++; $display("FAIL intr_after_ack got %b want 0", bus.INTR); end
  endtask

  task automatic test_two_src();
    bus.IRQ_IN = 4'b1010;
    ticks(3);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h0A) begin errors++; $display("FAIL pend_two got %h want 0a", rd); end
    ack();
    read_port(8'h22, rd);
    checks++; if (rd !== 8'h81) begin errors++; $display("FAIL cause_first got %h want 81", rd); end
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL pend_first got %h want 08", rd); end
    checks++; if (bus.INTR !== 1'b1) begin errors++; $display("FAIL intr_still got %b want 1", bus.INTR); end
    ack();
    read_port(8'h22, rd);
    checks++; if (rd !== 8'h83) begin errors++; $display("FAIL cause_second got %h want 83", rd); end
    ticks(4);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL level_once got %h want 00", rd); end
    bus.IRQ_IN = 4'b0000;
    ticks(3);
  endtask

  task automatic test_masked();
    io_write(8'h20, 8'h00);
    bus.IRQ_IN = 4'b0001;
    ticks(3);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL masked_pend got %h want 01", rd); end
    checks++; if (bus.INTR !== 1'b0) begin errors++; $display("FAIL masked_intr got %b want 0", bus.INTR); end
    io_write(8'h20, 8'h01);
    checks++; if (bus.INTR !== 1'b1) begin errors++; $display("FAIL unmask_intr got %b want 1", bus.INTR); end
    read_port(8'h20, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL mask_read got %h want 01", rd); end
    bus.I_CLR = 1'b1; tick(); bus.I_CLR = 1'b0;
    checks++; if (bus.INTR !== 1'b0) begin errors++; $display("FAIL iflag_gate got %b want 0", bus.INTR); end
    bus.I_SET = 1'b1; tick(); bus.I_SET = 1'b0;
    checks++; if (bus.INTR !== 1'b1) begin errors++; $display("FAIL iflag_ungate got %b want 1", bus.INTR); end
  endtask

  task automatic test_set_wins();
    io_write(8'h21, 8'h01);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL w1c got %h want 00", rd); end
    bus.IRQ_IN = 4'b0000; ticks(3);
    bus.IRQ_IN = 4'b0001; ticks(2);
    io_write(8'h21, 8'h01);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL w1c_collide got %h want 01", rd); end
    bus.IRQ_IN = 4'b0000; ticks(3);
    bus.IRQ_IN = 4'b0001; ticks(2);
    ack();
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL ack_collide got %h want 01", rd); end
    read_port(8'h22, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL ack_collide_cause got %h want 80", rd); end
    ack();
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL ack_plain got %h want 00", rd); end
  endtask

  task automatic test_io_decode();
    bus.PORT_ID = 8'h22; #1;
    checks++; if (bus.IN_HIT !== 1'b1) begin errors++; $display("FAIL hit_cause got %b want 1", bus.IN_HIT); end
    checks++; if (bus.IN_DATA !== 8'h80) begin errors++; $display("FAIL data_cause got %h want 80", bus.IN_DATA); end
    bus.PORT_ID = 8'h30; #1;
    checks++; if (bus.IN_HIT !== 1'b0) begin errors++; $display("FAIL hit_other got %b want 0", bus.IN_HIT); end
    checks++; if (bus.IN_DATA !== 8'h00) begin errors++; $display("FAIL data_other got %h want 00", bus.IN_DATA); end
    bus.PORT_ID = 8'h21; #1;
    checks++; if (bus.IN_HIT !== 1'b1) begin errors++; $display("FAIL hit_pend got %b want 1", bus.IN_HIT); end
  endtask

  task automatic test_mid_reset();
    bus.IRQ_IN = 4'b0000; ticks(3);
    bus.IRQ_IN = 4'b0010; ticks(3);
    io_write(8'h20, 8'h03);
    checks++; if (bus.INTR !== 1'b1) begin errors++; $display("FAIL pre_reset_intr got %b want 1", bus.INTR); end
    RESET = 1'b1;
    read_port(8'h20, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL async_mask got %h want 00", rd); end
    checks++; if (bus.I_FLAG !== 1'b0) begin errors++; $display("FAIL async_iflag got %b want 0", bus.I_FLAG); end
    checks++; if (bus.INTR !== 1'b0) begin errors++; $display("FAIL async_intr got %b want 0", bus.INTR); end
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL async_pend got %h want 00", rd); end
    read_port(8'h22, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL async_cause got %h want 00", rd); end
    checks++; if (bus.IN_HIT !== 1'b1) begin errors++; $display("FAIL reset_hit got %b want 1", bus.IN_HIT); end
    ticks(2);
    RESET = 1'b0;
    ticks(3);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL held_across_rst got %h want 02", rd); end
    io_write(8'h21, 8'h02);
    ticks(3);
    read_port(8'h21, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL held_once got %h want 00", rd); end
  endtask

  initial begin
    bus.IRQ_IN = '0; bus.I_SET = 1'b0; bus.I_CLR = 1'b0; bus.INTR_ACK = 1'b0;
    bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
    test_reset();
    test_iflag();
    test_single_irq();
    test_two_src();
    test_masked();
    test_set_wins();
    test_io_decode();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of interrupt sources (range 1..8).
REQ-002 The block SHALL have parameter MASK_PORT_ID, default 8'h20, meaning the I/O port ID of the mask register (read/write).
REQ-003 The block SHALL have parameter PEND_PORT_ID, default 8'h21, meaning the I/O port ID of the pending register (read, write-1-to-clear).
REQ-004 The block SHALL have parameter CAUSE_PORT_ID, default 8'h22, meaning the I/O port ID of the cause register (read-only).
REQ-005 The block SHALL have port CLK, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port IRQ_IN, input, NUM_SRC bits: asynchronous external interrupt requests, one bit per source.
REQ-008 The block SHALL have port I_SET, input, 1 bit: from the control unit; sets the interrupt-enable flag.
REQ-009 The block SHALL have port I_CLR, input, 1 bit: from the control unit; clears the interrupt-enable flag.
REQ-010 The block SHALL have port INTR_ACK, input, 1 bit: high for exactly the one cycle the control unit spends in its interrupt state.
REQ-011 The block SHALL have port IO_STRB, input, 1 bit: output strobe from the control unit.
REQ-012 The block SHALL have port PORT_ID, input, 8 bits: I/O address.
REQ-013 The block SHALL have port OUT_PORT, input, 8 bits: I/O write data.
REQ-014 The block SHALL have port INTR, output, 1 bit: interrupt request to the control unit.
REQ-015 The block SHALL have port I_FLAG, output, 1 bit: current interrupt-enable flag.
REQ-016 The block SHALL have port IN_DATA, output, 8 bits: I/O read data.
REQ-017 The block SHALL have port IN_HIT, output, 1 bit: high when PORT_ID matches any of the block's three port IDs.

Function
REQ-018 Each IRQ_IN bit SHALL pass through a 2-flop synchronizer followed by a previous-value flop; the block SHALL detect a rising edge when the synchronized value is 1 and the previous value is 0.
REQ-019 A detected edge SHALL set PEND[i] on the next rising edge; an IRQ_IN high sampled at edge k SHALL appear in PEND after edge k+2.
REQ-020 A level held high SHALL produce exactly one event, and pulses shorter than one CLK period are not guaranteed to be captured.
REQ-021 INTR SHALL equal I_FLAG AND OR(PEND AND MASK), decoded only from registers, with no combinational path from any input.
REQ-022 A masked pending bit SHALL remain pending, and INTR SHALL assert once that bit is unmasked.
REQ-023 I_FLAG SHALL be set by I_SET and cleared by I_CLR; when both are asserted in the same cycle, I_CLR SHALL win.
REQ-024 On INTR_ACK, the block SHALL select the lowest-index bit set in PEND AND MASK, clear that PEND bit, and load CAUSE = {1'b1, 4'b0, index[2:0]}.
REQ-025 An INTR_ACK with PEND AND MASK equal to zero SHALL leave PEND and CAUSE unchanged.
REQ-026 When a new edge and a clear (by ack or W1C) hit the same bit in the same cycle, the set SHALL win so that no event is lost.
REQ-027 IO_STRB with PORT_ID = MASK_PORT_ID SHALL load MASK <= OUT_PORT[NUM_SRC-1:0].
REQ-028 IO_STRB with PORT_ID = PEND_PORT_ID SHALL clear PEND bits where OUT_PORT is 1 (REQ-026 applies).
REQ-029 IN_DATA SHALL be combinational on PORT_ID: MASK, PEND or CAUSE, zero-extended to 8 bits; for any other PORT_ID, IN_DATA SHALL be 8'h00.
REQ-030 Reading CAUSE SHALL have no side effects, and CAUSE SHALL hold its value until the next valid ack.

Reset
REQ-031 While RESET is high, the block SHALL asynchronously clear the synchronizers, the previous-value flops, PEND, MASK, CAUSE and I_FLAG.
REQ-032 While RESET is high, INTR SHALL be 0, I_FLAG SHALL be 0, IN_DATA SHALL follow the cleared registers, and IN_HIT SHALL remain PORT_ID-decoded.
REQ-033 An IRQ_IN held high across reset release SHALL produce one event 2 cycles after release.
REQ-034 A reset asserted mid-ack SHALL win, and a pending event at reset SHALL be lost.

Structure
REQ-035 The package rat_intr_pkg SHALL hold the NUM_SRC default, the three port-ID constants, the CAUSE field positions and the valid-bit constant.
REQ-036 The block SHALL use one sub-module, irq_edge_sync, containing the synchronizer and edge detector for one source, instantiated NUM_SRC times.
REQ-037 The priority encoder and the register file SHALL remain in intr_ctrl.

Verification
REQ-038 Scenario: I_SET, MASK=4'hF, pulse IRQ_IN[2] for 3 cycles -> PEND=4'b0100 after edge k+2, INTR=1, and INTR_ACK -> PEND=0, CAUSE=8'h82, INTR=0.
REQ-039 Scenario: IRQ_IN[1] and IRQ_IN[3] rise together, then ack twice -> CAUSE=8'h81, then CAUSE=8'h83, then PEND=0.
REQ-040 Scenario: MASK=4'b0000, I_FLAG=1, IRQ_IN[0] rises -> PEND[0]=1 and INTR=0; then write MASK=8'h01 -> INTR=1 on the next cycle.
REQ-041 Scenario: I_SET and I_CLR in the same cycle -> I_FLAG=0; ack with nothing pending -> CAUSE unchanged at 8'h00.
REQ-042 Scenario: a new edge on bit 0 coincides with a W1C write of 8'h01 to PEND_PORT_ID -> PEND[0]=1.
REQ-043 Scenario: PORT_ID=8'h22 -> IN_HIT=1 and IN_DATA=CAUSE; PORT_ID=8'h30 -> IN_HIT=0 and IN_DATA=8'h00; RESET pulsed mid-operation -> all registers 0 immediately.
